// File: rtl/alu_74181_seq.sv
// Slice-sequential 74181 ALU: one 4-bit slice reused LSB-first, carry and A=B held between slices.
// Latency WIDTH/4+1 cycles start-to-done; start is ignored unless IDLE, and ena low freezes all state.
// ALU_74181_SEQ_ACC_EN: acc_sel at start takes operand A from the current result f.
module alu_74181_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    input  logic             acc_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cn_out,
    output logic             equal
);
    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a, r_b, r_shadow, r_f;
    logic [3:0]       r_s;
    logic             r_m, r_cn, r_eq, r_cn_out, r_equal, r_busy, r_done;

    logic [3:0]       w_a4, w_b4, w_p, w_g, w_f4;
    logic [4:0]       w_c;
    logic [WIDTH-1:0] w_a_src;

    // p/g form of the 74181: slice value is p + g + carry, logic mode forces every internal carry high.
    always_comb begin
        w_a4 = r_a[3:0];
        w_b4 = r_b[3:0];
        w_p  = w_a4 | (w_b4 & {4{r_s[0]}}) | (~w_b4 & {4{r_s[1]}});
        w_g  = (w_a4 & w_b4 & {4{r_s[3]}}) | (w_a4 & ~w_b4 & {4{r_s[2]}});
        w_c  = '0;
        w_c[0] = ~r_cn;
        for (int i = 0; i < 4; i++) begin
            w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
        end
        w_f4 = (w_p & ~w_g) ^ (w_c[3:0] | {4{r_m}});
    end

`ifdef ALU_74181_SEQ_ACC_EN
    assign w_a_src = acc_sel ? r_f : a;
`else
    logic w_unused_acc_sel;
    assign w_unused_acc_sel = acc_sel;
    assign w_a_src = a;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_shadow <= '0;
            r_s      <= '0;
            r_m      <= 1'b0;
            r_cn     <= 1'b1;
            r_eq     <= 1'b0;
            r_f      <= '0;
            r_cn_out <= 1'b1;
            r_equal  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (ena) begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= w_a_src;
                        r_b     <= b;
                        r_s     <= s;
                        r_m     <= m;
                        r_cn    <= cn;
                        r_idx   <= '0;
                        r_eq    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    // Operands shift down so the active slice is always the low nibble.
                    r_shadow <= (r_shadow >> 4) | (WIDTH'(w_f4) << (WIDTH - 4));
                    r_a      <= r_a >> 4;
                    r_b      <= r_b >> 4;
                    r_cn     <= ~w_c[4];
                    r_eq     <= r_eq & (&w_f4);
                    r_idx    <= r_idx + IW'(1);
                    if (r_idx == IW'(N - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_f      <= r_shadow;
                    r_cn_out <= r_cn;
                    r_equal  <= r_eq;
                    r_done   <= 1'b1;
                    r_idx    <= '0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign f      = r_f;
    assign cn_out = r_cn_out;
    assign equal  = r_equal;
endmodule

// File: tb/tb_alu_74181_seq.sv
// Bench for alu_74181_seq: 16-bit and 8-bit instances, queue scoreboard fed by a datasheet-table model.
module tb_alu_74181_seq;
    typedef struct packed {
        logic [15:0] f;
        logic        co;
        logic        eq;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstb, ena, m, cn, acc_sel;
    logic [3:0]  s;
    logic        st16, busy16, done16, co16, eq16;
    logic [15:0] a16, b16, f16;
    logic        st8, busy8, done8, co8, eq8;
    logic [7:0]  a8, b8, f8;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    logic [15:0] last_f16 = '0;
    logic [15:0] last_f8 = '0;

    alu_74181_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(st16), .a(a16), .b(b16), .s(s), .m(m),
        .cn(cn), .acc_sel(acc_sel), .busy(busy16), .done(done16), .f(f16), .cn_out(co16), .equal(eq16)
    );
    alu_74181_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rstb(rstb), .ena(ena), .start(st8), .a(a8), .b(b8), .s(s), .m(m),
        .cn(cn), .acc_sel(acc_sel), .busy(busy8), .done(done8), .f(f8), .cn_out(co8), .equal(eq8)
    );

    // Arithmetic ops written as X + Y + carry, logic ops as the function table.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] sv, input logic mv, input logic cv);
        exp_t r;
        logic [15:0] mask, am, bm, nb, lf;
        logic [16:0] x, y, sum;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        am = a & mask;
        bm = b & mask;
        nb = ~b & mask;
        case (sv)
            4'd0:  begin x = {1'b0, am};        y = 17'd0;            end
            4'd1:  begin x = {1'b0, am | bm};   y = 17'd0;            end
            4'd2:  begin x = {1'b0, am | nb};   y = 17'd0;            end
            4'd3:  begin x = {1'b0, mask};      y = 17'd0;            end
            4'd4:  begin x = {1'b0, am};        y = {1'b0, am & nb};  end
            4'd5:  begin x = {1'b0, am | bm};   y = {1'b0, am & nb};  end
            4'd6:  begin x = {1'b0, am};        y = {1'b0, nb};       end
            4'd7:  begin x = {1'b0, am & nb};   y = {1'b0, mask};     end
            4'd8:  begin x = {1'b0, am};        y = {1'b0, am & bm};  end
            4'd9:  begin x = {1'b0, am};        y = {1'b0, bm};       end
            4'd10: begin x = {1'b0, am | nb};   y = {1'b0, am & bm};  end
            4'd11: begin x = {1'b0, am & bm};   y = {1'b0, mask};     end
            4'd12: begin x = {1'b0, am};        y = {1'b0, am};       end
            4'd13: begin x = {1'b0, am | bm};   y = {1'b0, am};       end
            4'd14: begin x = {1'b0, am | nb};   y = {1'b0, am};       end
            default: begin x = {1'b0, mask};    y = {1'b0, am};       end
        endcase
        sum = x + y + {16'd0, ~cv};
        case (sv)
            4'd0:  lf = ~am;
            4'd1:  lf = ~(am | bm);
            4'd2:  lf = ~am & bm;
            4'd3:  lf = 16'h0000;
            4'd4:  lf = ~(am & bm);
            4'd5:  lf = ~bm;
            4'd6:  lf = am ^ bm;
            4'd7:  lf = am & ~bm;
            4'd8:  lf = ~am | bm;
            4'd9:  lf = ~(am ^ bm);
            4'd10: lf = bm;
            4'd11: lf = am & bm;
            4'd12: lf = 16'hFFFF;
            4'd13: lf = am | ~bm;
            4'd14: lf = am | bm;
            default: lf = am;
        endcase
        r.f  = mv ? (lf & mask) : (sum[15:0] & mask);
        r.co = (w == 16) ? ~sum[16] : ~sum[8];
        r.eq = (r.f == mask);
        return r;
    endfunction

    task automatic issue(input bit w16, input logic [15:0] av, input logic [15:0] bv,
                         input logic [3:0] sv, input logic mv, input logic cv, input logic accv);
        exp_t e;
        logic [15:0] aeff;
        aeff = av;
`ifdef ALU_74181_SEQ_ACC_EN
        if (accv) aeff = w16 ? last_f16 : last_f8;
`endif
        e = model(w16 ? 16 : 8, aeff, bv, sv, mv, cv);
        if (w16) last_f16 = e.f; else last_f8 = e.f;
        q.push_back(e);
        s = sv; m = mv; cn = cv; acc_sel = accv;
        if (w16) begin st16 = 1'b1; a16 = av; b16 = bv; end
        else begin st8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; end
        @(negedge clk);
        st16 = 1'b0;
        st8 = 1'b0;
    endtask

    task automatic wait_done(input bit w16, output int lat, output bit to);
        to = 1'b1;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if ((w16 ? done16 : done8) === 1'b1) begin
                lat = i;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy16); end
        checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done16); end
        checks++; if (f16 !== 16'h0000) begin failures++; $display("FAIL reset_f: got %h expected 0000", f16); end
        checks++; if (co16 !== 1'b1) begin failures++; $display("FAIL reset_cn_out: got %b expected 1", co16); end
        checks++; if (eq16 !== 1'b0) begin failures++; $display("FAIL reset_equal: got %b expected 0", eq16); end
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add16;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
        checks++; if (busy16 !== 1'b1) begin failures++; $display("FAIL add16_busy: got %b expected 1", busy16); end
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || lat != 5) begin failures++; $display("FAIL add16_latency: got %0d (timeout %0d) expected 5", lat, to); end
        checks++; if (f16 !== 16'h2233 || f16 !== e.f) begin failures++; $display("FAIL add16_f: got %h expected 2233", f16); end
        checks++; if (co16 !== 1'b1) begin failures++; $display("FAIL add16_cn_out: got %b expected 1", co16); end
        checks++; if (eq16 !== e.eq) begin failures++; $display("FAIL add16_equal: got %b expected %b", eq16, e.eq); end
        checks++; if (busy16 !== 1'b0) begin failures++; $display("FAIL add16_busy_done: got %b expected 0", busy16); end
        @(negedge clk);
        checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL add16_done_pulse: got %b expected 0", done16); end
    endtask

    task automatic test_carry_ripple;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to) begin failures++; $display("FAIL ripple_timeout: no done within 30 cycles"); end
        checks++; if (f16 !== 16'h0000 || f16 !== e.f) begin failures++; $display("FAIL ripple_f: got %h expected 0000", f16); end
        checks++; if (co16 !== 1'b0 || co16 !== e.co) begin failures++; $display("FAIL ripple_cn_out: got %b expected 0", co16); end
    endtask

    task automatic test_sub_equal;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'h5A5A, 16'h5A5A, 4'b0110, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || f16 !== 16'hFFFF || f16 !== e.f) begin failures++; $display("FAIL sub_eq_f: got %h expected ffff", f16); end
        checks++; if (eq16 !== 1'b1) begin failures++; $display("FAIL sub_eq_equal: got %b expected 1", eq16); end
        checks++; if (co16 !== e.co) begin failures++; $display("FAIL sub_eq_cn_out: got %b expected %b", co16, e.co); end
        issue(1'b1, 16'h5A5A, 16'h5A5B, 4'b0110, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || f16 !== 16'hFFFE || f16 !== e.f) begin failures++; $display("FAIL sub_ne_f: got %h expected fffe", f16); end
        checks++; if (eq16 !== 1'b0) begin failures++; $display("FAIL sub_ne_equal: got %b expected 0", eq16); end
    endtask

    task automatic test_reset_mid;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'hFFFF, 16'hFFFF, 4'b1001, 1'b0, 1'b0, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || f16 !== e.f || co16 !== 1'b0 || eq16 !== 1'b1) begin failures++; $display("FAIL premid_result: got f=%h co=%b eq=%b expected ffff/0/1", f16, co16, eq16); end
        issue(1'b1, 16'h1111, 16'h2222, 4'b1001, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        checks++; if (busy16 !== 1'b0 || done16 !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl: got busy=%b done=%b expected 0/0", busy16, done16); end
        checks++; if (f16 !== 16'h0000 || co16 !== 1'b1 || eq16 !== 1'b0) begin failures++; $display("FAIL mid_reset_out: got f=%h co=%b eq=%b expected 0000/1/0", f16, co16, eq16); end
        q.delete();
        last_f16 = '0;
        last_f8 = '0;
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        issue(1'b1, 16'h00F0, 16'h0F10, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || lat != 5 || f16 !== 16'h1000 || f16 !== e.f) begin failures++; $display("FAIL post_reset_op: got f=%h lat=%0d expected 1000 lat 5", f16, lat); end
    endtask

    task automatic test_logic8_busy;
        int ndone = 0;
        int first = 0;
        exp_t e;
        issue(1'b0, 16'h000F, 16'h0033, 4'b0110, 1'b1, 1'b1, 1'b0);
        st8 = 1'b1;
        a8 = 8'hFF;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            st8 = 1'b0;
            if (done8 === 1'b1) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        e = q.pop_front();
        checks++; if (first != 3) begin failures++; $display("FAIL logic8_latency: got %0d expected 3", first); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL logic8_single_done: got %0d expected 1", ndone); end
        checks++; if (f8 !== 8'h3C || {8'h00, f8} !== e.f) begin failures++; $display("FAIL logic8_xor: got %h expected 3c", f8); end
    endtask

    task automatic test_acc;
        int lat; bit to; exp_t e; logic [7:0] req;
        issue(1'b0, 16'h0001, 16'h0002, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_done(1'b0, lat, to);
        e = q.pop_front();
        checks++; if (to || f8 !== 8'h03 || {8'h00, f8} !== e.f) begin failures++; $display("FAIL acc_first: got %h expected 03", f8); end
        @(negedge clk);
        issue(1'b0, 16'h0000, 16'h0004, 4'b1001, 1'b0, 1'b1, 1'b1);
        wait_done(1'b0, lat, to);
        e = q.pop_front();
`ifdef ALU_74181_SEQ_ACC_EN
        req = 8'h07;
`else
        req = 8'h04;
`endif
        checks++; if (to || f8 !== req || {8'h00, f8} !== e.f) begin failures++; $display("FAIL acc_chain: got %h expected %h", f8, req); end
        acc_sel = 1'b0;
    endtask

    task automatic test_ena_stall;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'h0100, 16'h0023, 4'b1001, 1'b0, 1'b0, 1'b0);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy16 !== 1'b1 || done16 !== 1'b0) begin failures++; $display("FAIL ena_freeze: got busy=%b done=%b expected 1/0", busy16, done16); end
        ena = 1'b1;
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || lat != 5 || f16 !== 16'h0124 || f16 !== e.f) begin failures++; $display("FAIL ena_result: got f=%h lat=%0d expected 0124 lat 5", f16, lat); end
        ena = 1'b0;
        @(negedge clk);
        checks++; if (done16 !== 1'b1) begin failures++; $display("FAIL ena_done_hold: got %b expected 1", done16); end
        ena = 1'b1;
        @(negedge clk);
        checks++; if (done16 !== 1'b0) begin failures++; $display("FAIL ena_done_fall: got %b expected 0", done16); end
    endtask

    task automatic test_back_to_back;
        int lat; bit to; exp_t e;
        issue(1'b1, 16'h00AA, 16'h0055, 4'b1110, 1'b1, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || f16 !== e.f) begin failures++; $display("FAIL b2b_first: got %h expected %h", f16, e.f); end
        issue(1'b1, 16'h7000, 16'h9000, 4'b1001, 1'b0, 1'b1, 1'b0);
        wait_done(1'b1, lat, to);
        e = q.pop_front();
        checks++; if (to || lat != 5) begin failures++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        checks++; if (f16 !== e.f || co16 !== e.co || eq16 !== e.eq) begin failures++; $display("FAIL b2b_second: got %h/%b/%b expected %h/%b/%b", f16, co16, eq16, e.f, e.co, e.eq); end
    endtask

    task automatic test_random;
        int lat; bit to; exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            wait_done(1'b1, lat, to);
            e = q.pop_front();
            checks++;
            if (to || f16 !== e.f || co16 !== e.co || eq16 !== e.eq) begin
                failures++;
                $display("FAIL random_%0d: got %h/%b/%b expected %h/%b/%b (s=%b m=%b)", i, f16, co16, eq16, e.f, e.co, e.eq, s, m);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; s = '0; m = 1'b0; cn = 1'b1; acc_sel = 1'b0;
        st16 = 1'b0; a16 = '0; b16 = '0; st8 = 1'b0; a8 = '0; b8 = '0;
        test_reset();
        test_add16();
        test_carry_ripple();
        test_sub_equal();
        test_reset_mid();
        test_logic8_busy();
        test_acc();
        test_ena_stall();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
